// File: rtl/fibo_seq_ctrl.sv
// fibo_seq_ctrl
// Drives an external combinational ALU with ADD operations to produce a
// Fibonacci-style term stream from two seeds. Terms are emitted one at a
// time over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start, abort    begin a sequence (IDLE only) / cancel a running one
//   seed_a, seed_b  first and second terms, sampled at an accepted start
//   n_terms         number of terms to emit (0 = none, done only)
//   out_data/out_valid/out_ready  term output handshake
//   busy, done, ovf status: running, completion pulse, sticky carry seen
//   alu_op/alu_a/alu_b  ALU request; alu_y/alu_cf  ALU result and carry
module fibo_seq_ctrl #(
  parameter int unsigned    WIDTH  = 6,
  parameter int unsigned    OPW    = 3,
  parameter logic [OPW-1:0] OP_ADD = 3'b000,
  parameter logic [OPW-1:0] OP_NOP = 3'b111,
  parameter int unsigned    NW     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [NW-1:0]    n_terms,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OUT,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (n_terms != '0) begin
            ra_d    = seed_a;
            rb_d    = seed_b;
            cnt_d   = n_terms;
            state_d = S_OUT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          cnt_d   = cnt_q - NW'(1);
          state_d = (cnt_q == NW'(1)) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        ra_d    = rb_q;
        rb_d    = alu_y;
        ovf_d   = ovf_q | alu_cf;
        state_d = S_OUT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any pending handshake/CALC update; datapath and ovf
    // keep their current values so the last state stays observable.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ra_d    = ra_q;
      rb_d    = rb_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
    end
  end

  always_comb begin
    out_data  = ra_q;
    alu_a     = ra_q;
    alu_b     = rb_q;
    out_valid = (state_q == S_OUT);
    busy      = (state_q == S_OUT) || (state_q == S_CALC);
    done      = (state_q == S_DONE);
    ovf       = ovf_q;
    alu_op    = (state_q == S_CALC) ? OP_ADD : OP_NOP;
  end

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Testbench for fibo_seq_ctrl: randomized sequences checked by a queue
// scoreboard fed from a plain-arithmetic Fibonacci reference model.
module tb_fibo_seq_ctrl;

  localparam int unsigned    WIDTH  = 6;
  localparam int unsigned    OPW    = 3;
  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_NOP = 3'b111;
  localparam int unsigned    NW     = 4;
  localparam int             MOD    = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort, out_ready;
  logic [WIDTH-1:0] seed_a, seed_b;
  logic [NW-1:0]    n_terms;
  logic [WIDTH-1:0] out_data, alu_a, alu_b, alu_y;
  logic             out_valid, busy, done, ovf, alu_cf;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH:0]   alu_sum;

  fibo_seq_ctrl #(
    .WIDTH(WIDTH), .OPW(OPW), .OP_ADD(OP_ADD), .OP_NOP(OP_NOP), .NW(NW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .seed_a(seed_a), .seed_b(seed_b), .n_terms(n_terms),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .ovf(ovf),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_cf(alu_cf)
  );

  // External combinational ALU (ADD only; NOP yields zero)
  assign alu_sum = (alu_op == OP_ADD) ? ({1'b0, alu_a} + {1'b0, alu_b}) : '0;
  assign alu_y   = alu_sum[WIDTH-1:0];
  assign alu_cf  = alu_sum[WIDTH];

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int pops = 0;
  bit last_ovf;

  logic [WIDTH-1:0] exp_q[$];
  bit               done_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: t0=a, t1=b, t(k)=t(k-1)+t(k-2) mod 2^WIDTH. One ADD is issued
  // after every emitted term except the last, so n-1 sums feed ovf.
  task automatic model_push(input int a, input int b, input int n);
    int x, y, s;
    bit c;
    x = a; y = b; c = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(x[WIDTH-1:0]);
      if (i < n - 1) begin
        s = x + y;
        if (s >= MOD) c = 1'b1;
        x = y;
        y = s % MOD;
      end
    end
    done_q.push_back(c);
    last_ovf = c;
  endtask

  // Monitor / scoreboard
  bit               stall = 1'b0;
  logic [WIDTH-1:0] stall_data;
  always @(negedge clk) begin
    if (!rst) begin
      stall = 1'b0;
    end else begin
      if (stall) chk("stall_hold", {out_valid, out_data}, {1'b1, stall_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_term");
        else chk("term", out_data, exp_q.pop_front());
        pops++;
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
      if (alu_op != OP_NOP)
        chk("alu_op_calc_only", {alu_op, busy, out_valid}, {OP_ADD, 1'b1, 1'b0});
      if (done) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else chk("ovf_at_done", ovf, done_q.pop_front());
        chk("terms_left_at_done", exp_q.size(), 0);
        chk("done_not_busy", {busy, out_valid}, 2'b00);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_seq(input int a, input int b, input int n, input bit rnd, input bit poke);
    int start_cyc, d0;
    bit fin;
    model_push(a, b, n);
    seed_a    = a[WIDTH-1:0];
    seed_b    = b[WIDTH-1:0];
    n_terms   = n[NW-1:0];
    start     = 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    d0        = done_cnt;
    seed_a    = WIDTH'($urandom);
    seed_b    = WIDTH'($urandom);
    n_terms   = NW'($urandom);
    if (n == 0) chk("zero_n_done_only", {out_valid, done}, 2'b01);
    else        chk("valid_after_start", {out_valid, busy}, 2'b11);
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      start     = (poke && i == 3);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_cnt != d0) fin = 1'b1;
      else tick();
    end
    start = 1'b0;
    if (!fin) fail_now("done_timeout");
    else if (!rnd) chk("done_latency", done_cyc - start_cyc, (n == 0) ? 0 : 2 * n - 1);
    out_ready = 1'b0;
    repeat (3) tick();
    chk("ovf_held_after_done", {ovf, busy, done}, {last_ovf, 2'b00});
  endtask

  task automatic run_abort();
    int p0;
    bit hit;
    exp_q.push_back(6'd1);
    exp_q.push_back(6'd2);
    p0 = pops;
    seed_a = 6'd1; seed_b = 6'd2; n_terms = 4'd8;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (pops - p0 >= 2) hit = 1'b1;
      else tick();
    end
    if (!hit) fail_now("abort_wait_timeout");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {busy, out_valid, done, ovf}, 4'b0000);
    repeat (4) tick();
    chk("abort_no_extra", {exp_q.size(), done_q.size(), busy}, 0);
  endtask

  task automatic run_reset_mid();
    model_push(5, 9, 8);
    seed_a = 6'd5; seed_b = 6'd9; n_terms = 4'd8;
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("pre_reset_out", {out_valid, out_data}, {1'b1, 6'd5});
    #2 rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("async_reset_vals",
        {out_data, out_valid, busy, done, ovf, alu_op, alu_a, alu_b},
        {6'd0, 4'b0000, OP_NOP, 6'd0, 6'd0});
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("idle_after_reset", {out_valid, busy, done}, 3'b000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    seed_a = '0; seed_b = '0; n_terms = '0;
    #1 rst = 1'b0;
    #2;
    chk("reset_vals",
        {out_data, out_valid, busy, done, ovf, alu_op, alu_a, alu_b},
        {6'd0, 4'b0000, OP_NOP, 6'd0, 6'd0});
    repeat (2) tick();
    rst = 1'b1;
    tick();

    run_seq(1, 2, 8, 1'b0, 1'b1);   // basic, with ignored start mid-run
    run_seq(1, 2, 10, 1'b0, 1'b0);  // wraps to 25, ovf set
    run_seq(1, 2, 4, 1'b1, 1'b0);   // backpressure
    run_seq(1, 2, 1, 1'b0, 1'b0);
    run_seq(1, 2, 0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_seq($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
              $urandom_range(0, 15), k[0], 1'b0);
    run_abort();
    run_seq(3, 3, 3, 1'b0, 1'b0);
    run_reset_mid();
    run_seq(7, 60, 6, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fibo_seq_ctrl.md
# fibo_seq_ctrl

Sequencer that drives the lab ALU to generate a Fibonacci-style term stream from two seed operands. It issues ADD operations to an external combinational ALU, captures each result, and delivers terms one at a time over a valid/ready output handshake. It sits between the top-level switches/start logic and the ALU, replacing hand-sequenced operand loading.

## Interface
- WIDTH, 6: operand/result width (matches operand bus).
- OPW, 3: ALU opcode width (matches opcode bus).
- OP_ADD, 3'b000: opcode driven for addition.
- OP_NOP, 3'b111: opcode driven when no operation is issued.
- NW, 4: width of term-count input.

- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to begin a sequence.
- abort  in  1  synchronous cancel of a running sequence.
- seed_a  in  WIDTH  first term.
- seed_b  in  WIDTH  second term.
- n_terms  in  NW  number of terms to emit.
- out_data  out  WIDTH  current term.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts term.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at normal completion.
- ovf  out  1  sticky: some ADD produced carry-out.
- alu_op  out  OPW  opcode to ALU.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_y  in  WIDTH  ALU result (combinational from alu_op/a/b).
- alu_cf  in  1  ALU carry-out.

## Operation
- Registers: r_a, r_b (WIDTH), cnt (NW), ovf, state.
- alu_a = r_a, alu_b = r_b at all times; alu_op = OP_ADD only in CALC, else OP_NOP.
- out_data = r_a; out_valid = 1 only in OUT.
- busy = 1 in OUT and CALC.
- States:
  - IDLE: on start with n_terms != 0: r_a<=seed_a, r_b<=seed_b, cnt<=n_terms, ovf<=0, go OUT. start with n_terms == 0: go DONE (no term emitted, ovf cleared).
  - OUT: hold out_data until out_valid & out_ready. On handshake: cnt<=cnt-1; if cnt==1 go DONE, else go CALC.
  - CALC: one cycle; r_a<=r_b, r_b<=alu_y, ovf<=ovf|alu_cf; go OUT.
  - DONE: done=1 for exactly one cycle; go IDLE.
- Emitted sequence: seed_a, seed_b, seed_a+seed_b, ... ; sums wrap modulo 2^WIDTH, sequence continues after carry.
- start ignored outside IDLE. seed/n_terms sampled only at accepted start.
- abort (any state except IDLE) -> IDLE next edge, no done pulse, r_a/r_b/ovf retain values; abort has priority over handshake and start.
- ovf remains readable after completion until next accepted start or reset.

## Timing
- Reset (rst=0, async): state IDLE; r_a=r_b=0, cnt=0; out_data=0, out_valid=0, busy=0, done=0, ovf=0, alu_op=OP_NOP, alu_a=alu_b=0.
- Start sampled at edge k -> out_valid=1 from cycle after k.
- Handshake at edge m (not last) -> CALC during cycle m+1 -> next term valid after edge m+2. With out_ready held 1: one term per 2 cycles.
- Last handshake at edge m -> done high cycle after m, busy low same cycle, IDLE after m+2.
- out_data/out_valid stable while out_valid & !out_ready (no change, no drop).
- rst asserted mid-sequence: immediate return to reset values, no done.

## Test plan
- Reset: rst=0 mid-OUT -> all outputs to reset values asynchronously; after release, out_valid stays 0 until start.
- Basic: seed_a=1, seed_b=2, n_terms=8, out_ready=1 -> terms 1,2,3,5,8,13,21,34 at 2-cycle spacing; one done pulse; ovf=0.
- Overflow: same seeds, n_terms=10 -> ...,34,55,25; ovf=1 after the CALC producing 25 (34+55=89, carry) and held after done.
- Backpressure: n_terms=4, out_ready toggled pseudo-randomly -> exactly 1,2,3,5 accepted in order, out_data stable while stalled, alu_op=OP_ADD only in CALC cycles.
- Edge counts: n_terms=1 -> single term 1 then done; n_terms=0 -> no out_valid, done pulse cycle after start.
- Control: start during busy ignored (sequence unchanged); abort after second term -> IDLE next cycle, no done, new start with seeds 3,3 yields 3,3,6.
